present_round_ctrl: RTL and testbench

- Sequencing controller for the round-based, pipelined threshold PRESENT core.
- Drives the select lines of the state and key mux-flip-flop banks: load external input, or feed back the round-function output.
- Also generates the round counter for the key schedule, per-round stage timing and the start/done handshake.
- Sits beside the datapath in the cipher top level; carries no data itself.

---
 rtl/present_round_ctrl.sv | 134 +++++++++++++
 tb/tb_present_round_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/present_round_ctrl.sv
// ---------------------------------------------------------------------------
// present_round_ctrl : round/stage sequencer and start/done handshake for the
//                      pipelined threshold PRESENT core (mux-FF selects).
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module present_round_ctrl #(
  parameter int ROUNDS = 31,
  parameter int STAGES = 4,
  parameter int CW     = 5,
  parameter int SW     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          ready,
  output logic          busy,
  output logic          state_sel,
  output logic          key_sel,
  output logic          key_upd,
  output logic [CW-1:0] round_cnt,
  output logic [SW-1:0] stage_cnt,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [SW-1:0] c_last_stage = SW'(STAGES - 1);
  localparam logic [CW-1:0] c_last_round = CW'(ROUNDS);
  localparam logic [SW-1:0] c_stage_one  = SW'(1);
  localparam logic [CW-1:0] c_round_one  = CW'(1);

  state_e        state_q;
  logic [CW-1:0] round_q;
  logic [SW-1:0] stage_q;
  logic          ready_q;
  logic          busy_q;
  logic          sel_q;
  logic          key_upd_q;
  logic          done_q;

  // Outputs are computed one cycle ahead so every port is a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      round_q   <= '0;
      stage_q   <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      sel_q     <= 1'b1;
      key_upd_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= S_RUN;
            round_q   <= c_round_one;
            stage_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            sel_q     <= 1'b0;
            key_upd_q <= (c_last_stage == '0);
          end else begin
            round_q   <= '0;
            stage_q   <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            sel_q     <= 1'b1;
            key_upd_q <= 1'b0;
          end
        end

        S_RUN: begin
          if (stage_q == c_last_stage) begin
            stage_q <= '0;
            if (round_q == c_last_round) begin
              state_q   <= S_DONE;
              round_q   <= '0;
              key_upd_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              round_q   <= round_q + c_round_one;
              key_upd_q <= (c_last_stage == '0);
            end
          end else begin
            stage_q   <= stage_q + c_stage_one;
            key_upd_q <= ((stage_q + c_stage_one) == c_last_stage);
          end
        end

        S_DONE: begin
          state_q   <= S_IDLE;
          round_q   <= '0;
          stage_q   <= '0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          sel_q     <= 1'b1;
          key_upd_q <= 1'b0;
          done_q    <= 1'b0;
        end

        default: begin
          state_q   <= S_IDLE;
          round_q   <= '0;
          stage_q   <= '0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          sel_q     <= 1'b1;
          key_upd_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign state_sel = sel_q;
  assign key_sel   = sel_q;
  assign key_upd   = key_upd_q;
  assign round_cnt = round_q;
  assign stage_cnt = stage_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_present_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_present_round_ctrl : directed bench for present_round_ctrl, default
//                         (31 rounds / 4 stages) and 3 rounds / 1 stage.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_present_round_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;

  logic       rdy0, bsy0, ss0, ks0, ku0, dn0;
  logic [4:0] rc0;
  logic [1:0] sc0;
  logic       rdy1, bsy1, ss1, ks1, ku1, dn1;
  logic [4:0] rc1;
  logic [0:0] sc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  present_round_ctrl #(.ROUNDS(31), .STAGES(4), .CW(5), .SW(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ready(rdy0), .busy(bsy0),
    .state_sel(ss0), .key_sel(ks0), .key_upd(ku0), .round_cnt(rc0),
    .stage_cnt(sc0), .done(dn0)
  );

  present_round_ctrl #(.ROUNDS(3), .STAGES(1), .CW(5), .SW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ready(rdy1), .busy(bsy1),
    .state_sel(ss1), .key_sel(ks1), .key_upd(ku1), .round_cnt(rc1),
    .stage_cnt(sc1), .done(dn1)
  );

  // {ready, busy, state_sel, key_sel, key_upd, done, round_cnt, stage_cnt}
  wire [12:0] obs0 = {rdy0, bsy0, ss0, ks0, ku0, dn0, rc0, sc0};
  wire [11:0] obs1 = {rdy1, bsy1, ss1, ks1, ku1, dn1, rc1, sc1};

  localparam logic [12:0] c_idle0 = {6'b101100, 5'd0, 2'd0};
  localparam logic [11:0] c_idle1 = {6'b101100, 5'd0, 1'd0};

  // Expected outputs of the default instance c cycles after the accepting edge.
  function automatic logic [12:0] exp0(input int c);
    logic [12:0] v;
    if (c <= 124)
      v = {4'b0100, (c % 4 == 0), 1'b0, 5'((c - 1) / 4 + 1), 2'((c - 1) % 4)};
    else if (c == 125)
      v = {6'b010001, 5'd0, 2'd0};
    else
      v = c_idle0;
    return v;
  endfunction

  task automatic check(input string tag, input int cyc,
                       input logic [12:0] obs, input logic [12:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One default-instance transaction; start is raised now (cycle 0).
  task automatic run0(input string tag, input bit hold, input bit pulses,
                      input bit restart);
    start0 = 1'b1;
    for (int c = 1; c <= 126; c++) begin
      step();
      check(tag, c, obs0, exp0(c));
      if (c == 126)
        start0 = restart;
      else
        start0 = hold | (pulses & (c == 10 || c == 60 || c == 125));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;

    // Reset held with start toggling
    for (int i = 0; i < 3; i++) begin
      start0 = i[0];
      start1 = ~i[0];
      step();
      check("reset0", i, obs0, c_idle0);
      check("reset1", i, {1'b0, obs1}, {1'b0, c_idle1});
    end
    start0 = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    step();
    check("idle0", 0, obs0, c_idle0);
    step();
    check("idle0_hold", 0, obs0, c_idle0);

    run0("nominal", 1'b0, 1'b0, 1'b0);
    step();
    check("post_nominal", 0, obs0, c_idle0);

    run0("start_busy", 1'b0, 1'b1, 1'b0);
    step();
    check("post_busy", 0, obs0, c_idle0);

    // Reset in round 10, stage 2 (cycle 39)
    start0 = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      step();
      start0 = 1'b0;
      check("pre_abort", c, obs0, exp0(c));
    end
    #2 rst_n = 1'b0;
    #1 check("async_rst", 39, obs0, c_idle0);
    for (int i = 0; i < 2; i++) begin
      start0 = ~start0;
      step();
      check("in_rst", i, obs0, c_idle0);
    end
    start0 = 1'b0;
    rst_n  = 1'b1;
    step();
    check("after_rst", 0, obs0, c_idle0);
    run0("fresh", 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high
    run0("b2b_first", 1'b1, 1'b0, 1'b1);
    run0("b2b_second", 1'b1, 1'b0, 1'b0);
    step();
    check("post_b2b", 0, obs0, c_idle0);

    // Single-stage instance: 3 rounds, done at cycle 4
    start1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start1 = (c == 2);
      if (c <= 3)
        check("s1_run", c, {1'b0, obs1}, {1'b0, 4'b0100, 1'b1, 1'b0, 5'(c), 1'b0});
      else if (c == 4)
        check("s1_done", c, {1'b0, obs1}, {1'b0, 6'b010001, 5'd0, 1'b0});
      else
        check("s1_idle", c, {1'b0, obs1}, {1'b0, c_idle1});
    end
    check("dut0_quiet", 0, obs0, c_idle0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
